// File: rtl/cubehash_pkg.sv
// Shared constants and types for the CubeHash message front end.
// Block geometry, pad byte, feeder states and byte-lane index type.
package cubehash_pkg;

    localparam int         BLOCK_BYTES = 32;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLK_W       = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        PADBLK
    } state_t;

    typedef logic [4:0] lane_t;

    localparam lane_t LAST_LANE = lane_t'(BLOCK_BYTES - 1);

endpackage

// File: rtl/cubehash_byte_lane_wr.sv
// Byte-lane write-enable decoder for the block buffer.
// Data lands at idx; the pad byte lands at idx or idx+1.
module cubehash_byte_lane_wr
    import cubehash_pkg::*;
(
    input  logic                   data_en,
    input  logic                   pad_here,
    input  logic                   pad_next,
    input  lane_t                  idx,
    output logic [BLOCK_BYTES-1:0] data_we,
    output logic [BLOCK_BYTES-1:0] pad_we
);

    lane_t nxt;

    always_comb begin
        nxt     = idx + lane_t'(1);
        data_we = '0;
        pad_we  = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            data_we[i] = data_en && (idx == lane_t'(i));
            pad_we[i]  = (pad_here && (idx == lane_t'(i)))
                      || (pad_next && (nxt == lane_t'(i)));
        end
    end

endmodule

// File: rtl/cubehash_pad_feeder.sv
// Packs a byte stream into padded 256-bit CubeHash blocks.
// Optional msg_len output enabled by defining CUBEHASH_MSG_LEN_EN.
module cubehash_pad_feeder
    import cubehash_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_last
`ifdef CUBEHASH_MSG_LEN_EN
    ,
    output logic [63:0]      msg_len
`endif
);

    state_t state, next_state;
    lane_t  cnt;
    logic   pend_pad;
    logic   live;
    logic   accept, emit_hs, is_full;
    logic   data_en, pad_here, pad_next;
    logic [BLOCK_BYTES-1:0] data_we, pad_we;

    assign is_full = (cnt == LAST_LANE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FILL:
                if (accept && (in_empty || in_last || is_full))
                    next_state = EMIT;
            EMIT:
                if (blk_ready)
                    next_state = pend_pad ? PADBLK : FILL;
            PADBLK:  next_state = EMIT;
            default: next_state = FILL;
        endcase
    end

    // in_empty takes priority over in_last for every decision below
    always_comb begin
        in_ready  = live && (state == FILL);
        blk_valid = (state == EMIT);
        accept    = in_valid && in_ready;
        emit_hs   = blk_valid && blk_ready;
        data_en   = accept && !in_empty;
        pad_here  = (accept && in_empty) || (state == PADBLK);
        pad_next  = data_en && in_last && !is_full;
    end

    cubehash_byte_lane_wr u_lane_wr (
        .data_en  (data_en),
        .pad_here (pad_here),
        .pad_next (pad_next),
        .idx      (cnt),
        .data_we  (data_we),
        .pad_we   (pad_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            cnt      <= '0;
            pend_pad <= 1'b0;
            blk_last <= 1'b0;
            blk_data <= '0;
        end else begin
            live <= 1'b1;
            if (emit_hs)      cnt <= '0;
            else if (data_en) cnt <= cnt + lane_t'(1);
            if (data_en && in_last && is_full) pend_pad <= 1'b1;
            else if (state == PADBLK)          pend_pad <= 1'b0;
            if (emit_hs)                   blk_last <= 1'b0;
            else if (pad_here || pad_next) blk_last <= 1'b1;
            // clearing on emit gives the zero-fill for free
            if (emit_hs) begin
                blk_data <= '0;
            end else begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    if (pad_we[i])       blk_data[8*i +: 8] <= PAD_BYTE;
                    else if (data_we[i]) blk_data[8*i +: 8] <= in_data;
                end
            end
        end
    end

`ifdef CUBEHASH_MSG_LEN_EN
    logic len_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_len <= '0;
            len_clr <= 1'b0;
        end else begin
            if (emit_hs && blk_last) len_clr <= 1'b1;
            else if (accept)         len_clr <= 1'b0;
            if (accept) begin
                if (len_clr)
                    msg_len <= data_en ? 64'd1 : 64'd0;
                else if (data_en && !(&msg_len))
                    msg_len <= msg_len + 64'd1;
            end
        end
    end
`endif

endmodule
